// File: rtl/balance_db_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// balance_db_arbiter_pkg
// Shared definitions for the ATM balance-memory arbiter:
//   - default sizing constants (requesters, accounts, index and balance widths)
//   - transaction opcodes as seen on req_op
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package balance_db_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int NUM_ACC_DEF = 10;
  localparam int IDX_W_DEF   = 4;
  localparam int BAL_W_DEF   = 16;
  localparam int OP_W        = 2;

  typedef enum logic [1:0] {
    OP_READ     = 2'd0,
    OP_WITHDRAW = 2'd1,
    OP_DEPOSIT  = 2'd2,
    OP_TRANSFER = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_SRC  = 3'd1,
    ST_CHK_SRC = 3'd2,
    ST_RD_DST  = 3'd3,
    ST_CHK_DST = 3'd4,
    ST_WR_SRC  = 3'd5,
    ST_WR_DST  = 3'd6,
    ST_RESP    = 3'd7
  } state_e;

endpackage : balance_db_arbiter_pkg

// File: rtl/balance_db_arbiter_if.sv
// -----------------------------------------------------------------------------
// balance_db_arbiter_if
// Bundles the requester handshake (req_*/rsp_*/busy) and the single-port
// balance-memory bus (mem_*) of the arbiter.
//   slave  : the arbiter side (consumes requests, drives responses and memory)
//   master : the environment side (terminals plus balance RAM)
// Signals:
//   req_valid/op/src/dst/amount : per-requester request fields, packed by index
//   req_ready, rsp_valid        : one-hot pulses toward the requesters
//   rsp_error, rsp_balance      : result, qualified by any rsp_valid bit
//   busy                        : a transaction is in flight
//   mem_en/we/addr/wdata/rdata  : balance RAM port, rdata one cycle after a read
// -----------------------------------------------------------------------------
interface balance_db_arbiter_if
  import balance_db_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int BAL_W   = BAL_W_DEF
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [OP_W*NUM_REQ-1:0]  req_op;
  logic [IDX_W*NUM_REQ-1:0] req_src;
  logic [IDX_W*NUM_REQ-1:0] req_dst;
  logic [BAL_W*NUM_REQ-1:0] req_amount;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic                     rsp_error;
  logic [BAL_W-1:0]         rsp_balance;
  logic                     busy;
  logic                     mem_en;
  logic                     mem_we;
  logic [IDX_W-1:0]         mem_addr;
  logic [BAL_W-1:0]         mem_wdata;
  logic [BAL_W-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_op, req_src, req_dst, req_amount, mem_rdata,
    output req_ready, rsp_valid, rsp_error, rsp_balance, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_src, req_dst, req_amount, mem_rdata,
    input  req_ready, rsp_valid, rsp_error, rsp_balance, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface : balance_db_arbiter_if

// File: rtl/balance_db_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// balance_db_arbiter_rr_arbiter
// Combinational round-robin pick: the first asserted request at or after
// ptr_i, searching cyclically, wins.
// Ports:
//   req_i       : request vector
//   ptr_i       : index with highest priority this round
//   en_i        : qualifies the search; no grant when low
//   gnt_o       : one-hot grant
//   gnt_idx_o   : binary index of the grant
//   gnt_valid_o : a grant was made
// -----------------------------------------------------------------------------
module balance_db_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  localparam logic [NUM_REQ-1:0] REQ_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  int   cand_s;
  logic hit_s;

  // Cyclic priority search; once a hit is found later candidates are masked.
  always_comb begin
    cand_s      = 0;
    hit_s       = 1'b0;
    gnt_idx_o   = {PTR_W{1'b0}};
    gnt_valid_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = int'(ptr_i) + k;
      cand_s      = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
      hit_s       = en_i && !gnt_valid_o && req_i[PTR_W'(cand_s)];
      gnt_idx_o   = hit_s ? PTR_W'(cand_s) : gnt_idx_o;
      gnt_valid_o = gnt_valid_o | hit_s;
    end
    gnt_o = gnt_valid_o ? (REQ_LSB << gnt_idx_o) : {NUM_REQ{1'b0}};
  end

endmodule : balance_db_arbiter_rr_arbiter

// File: rtl/balance_db_arbiter.sv
// -----------------------------------------------------------------------------
// balance_db_arbiter
// Round-robin arbiter and read-check-write sequencer that lets several ATM
// terminals share one single-port balance RAM. A granted request runs to
// completion (READ, WITHDRAW, DEPOSIT or TRANSFER) before the next grant, so
// each transaction is atomic with respect to the other requesters.
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   bus    : request/response handshake plus balance RAM port (slave side)
// Output timing: req_ready and rsp_* are registered from the state that
// decides them, so req_ready shows up with RD_SRC and rsp_valid one cycle
// after RESP. Memory strobes are registered from the next state so that they
// line up with the RD_*/WR_* states themselves.
// -----------------------------------------------------------------------------
module balance_db_arbiter
  import balance_db_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int NUM_ACC = NUM_ACC_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int BAL_W   = BAL_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  balance_db_arbiter_if.slave bus
);

  localparam int                 PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] REQ_LSB   = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   ACC_LIMIT = IDX_W'(NUM_ACC);
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_REQ - 1);

  // FSM and captured transaction
  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  op_e                op_q, op_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   dst_q, dst_d;
  logic [BAL_W-1:0]   amt_q, amt_d;
  logic [BAL_W-1:0]   bal_s_q, bal_s_d;
  logic [BAL_W-1:0]   bal_d_q, bal_d_d;
  logic [BAL_W-1:0]   new_s_q, new_s_d;
  logic               err_q, err_d;

  // Registered outputs
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_error_q, rsp_error_d;
  logic [BAL_W-1:0]   rsp_balance_q, rsp_balance_d;
  logic               busy_q, busy_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [IDX_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BAL_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Arbiter and arithmetic
  logic               arb_en_s;
  logic [NUM_REQ-1:0] arb_gnt_s;
  logic [PTR_W-1:0]   arb_idx_s;
  logic               arb_valid_s;
  logic [BAL_W:0]     sum_s;
  logic [BAL_W-1:0]   diff_s;
  logic [BAL_W-1:0]   credit_s;

  // Only arbitrate while idle so a running sequence cannot be interrupted.
  assign arb_en_s = (state_q == ST_IDLE);

  balance_db_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .en_i        (arb_en_s),
    .gnt_o       (arb_gnt_s),
    .gnt_idx_o   (arb_idx_s),
    .gnt_valid_o (arb_valid_s)
  );

  // One extra bit on the sum exposes deposit/credit overflow directly.
  assign sum_s    = {1'b0, bus.mem_rdata} + {1'b0, amt_q};
  assign diff_s   = bus.mem_rdata - amt_q;
  // Cannot wrap: CHK_DST already rejected an overflowing credit.
  assign credit_s = bal_d_q + amt_q;

  // Next-state, datapath capture and output decode.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    op_d          = op_q;
    src_d         = src_q;
    dst_d         = dst_q;
    amt_d         = amt_q;
    bal_s_d       = bal_s_q;
    bal_d_d       = bal_d_q;
    new_s_d       = new_s_q;
    err_d         = err_q;
    req_ready_d   = {NUM_REQ{1'b0}};
    rsp_valid_d   = {NUM_REQ{1'b0}};
    rsp_error_d   = 1'b0;
    rsp_balance_d = {BAL_W{1'b0}};
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = {IDX_W{1'b0}};
    mem_wdata_d   = {BAL_W{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          gnt_d       = arb_idx_s;
          op_d        = op_e'(bus.req_op[int'(arb_idx_s)*OP_W +: OP_W]);
          src_d       = bus.req_src[int'(arb_idx_s)*IDX_W +: IDX_W];
          dst_d       = bus.req_dst[int'(arb_idx_s)*IDX_W +: IDX_W];
          amt_d       = bus.req_amount[int'(arb_idx_s)*BAL_W +: BAL_W];
          // Clear stale results so an invalid-src response reports 0.
          bal_s_d     = {BAL_W{1'b0}};
          bal_d_d     = {BAL_W{1'b0}};
          new_s_d     = {BAL_W{1'b0}};
          err_d       = 1'b0;
          rr_ptr_d    = (arb_idx_s == PTR_LAST) ? {PTR_W{1'b0}} : (arb_idx_s + PTR_W'(1));
          req_ready_d = arb_gnt_s;
          state_d     = ST_RD_SRC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_SRC: begin
        if (src_q >= ACC_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_CHK_SRC;
        end
      end

      ST_CHK_SRC: begin
        bal_s_d = bus.mem_rdata;
        case (op_q)
          OP_READ: begin
            new_s_d = bus.mem_rdata;
            state_d = ST_RESP;
          end
          OP_WITHDRAW: begin
            if (amt_q > bus.mem_rdata) begin
              err_d   = 1'b1;
              state_d = ST_RESP;
            end else begin
              new_s_d = diff_s;
              state_d = ST_WR_SRC;
            end
          end
          OP_DEPOSIT: begin
            if (sum_s[BAL_W]) begin
              err_d   = 1'b1;
              state_d = ST_RESP;
            end else begin
              new_s_d = sum_s[BAL_W-1:0];
              state_d = ST_WR_SRC;
            end
          end
          OP_TRANSFER: begin
            if ((dst_q >= ACC_LIMIT) || (dst_q == src_q) || (amt_q > bus.mem_rdata)) begin
              err_d   = 1'b1;
              state_d = ST_RESP;
            end else begin
              new_s_d = diff_s;
              state_d = ST_RD_DST;
            end
          end
          default: begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        endcase
      end

      ST_RD_DST: begin
        state_d = ST_CHK_DST;
      end

      ST_CHK_DST: begin
        bal_d_d = bus.mem_rdata;
        if (sum_s[BAL_W]) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WR_SRC;
        end
      end

      ST_WR_SRC: begin
        state_d = (op_q == OP_TRANSFER) ? ST_WR_DST : ST_RESP;
      end

      ST_WR_DST: begin
        state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid_d   = REQ_LSB << gnt_q;
        rsp_error_d   = err_q;
        rsp_balance_d = err_q ? bal_s_q : new_s_q;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Memory strobes follow the state being entered, so they are valid
    // during that state and read data returns in the following CHK state.
    case (state_d)
      ST_RD_SRC: begin
        mem_en_d   = (src_d < ACC_LIMIT);
        mem_addr_d = src_d;
      end
      ST_RD_DST: begin
        mem_en_d   = 1'b1;
        mem_addr_d = dst_q;
      end
      ST_WR_SRC: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = src_q;
        mem_wdata_d = new_s_d;
      end
      ST_WR_DST: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = dst_q;
        mem_wdata_d = credit_s;
      end
      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= {PTR_W{1'b0}};
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Captured request and intermediate balances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q   <= {PTR_W{1'b0}};
      op_q    <= OP_READ;
      src_q   <= {IDX_W{1'b0}};
      dst_q   <= {IDX_W{1'b0}};
      amt_q   <= {BAL_W{1'b0}};
      bal_s_q <= {BAL_W{1'b0}};
      bal_d_q <= {BAL_W{1'b0}};
      new_s_q <= {BAL_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      amt_q   <= amt_d;
      bal_s_q <= bal_s_d;
      bal_d_q <= bal_d_d;
      new_s_q <= new_s_d;
      err_q   <= err_d;
    end
  end

  // Output registers; a mid-transaction reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_q   <= {NUM_REQ{1'b0}};
      rsp_valid_q   <= {NUM_REQ{1'b0}};
      rsp_error_q   <= 1'b0;
      rsp_balance_q <= {BAL_W{1'b0}};
      busy_q        <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {IDX_W{1'b0}};
      mem_wdata_q   <= {BAL_W{1'b0}};
    end else begin
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_balance_q <= rsp_balance_d;
      busy_q        <= busy_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_balance = rsp_balance_q;
  assign bus.busy        = busy_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule : balance_db_arbiter

// File: tb/tb_balance_db_arbiter.sv
// -----------------------------------------------------------------------------
// tb_balance_db_arbiter
// Directed and randomized transactions against balance_db_arbiter with a
// 1-cycle-latency balance RAM and a behavioural account-ledger model.
// -----------------------------------------------------------------------------
module tb_balance_db_arbiter;
  import balance_db_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;

  // Balance RAM model with a backdoor for preloading.
  logic [15:0] mem [0:15];
  int          ref_mem [0:15];
  logic        bd_init;
  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [15:0] bd_data;
  int          wr_cnt;

  balance_db_arbiter_if #(.NUM_REQ(4), .IDX_W(4), .BAL_W(16)) bus ();

  balance_db_arbiter #(
    .NUM_REQ (4),
    .NUM_ACC (10),
    .IDX_W   (4),
    .BAL_W   (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'd500;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
    if (bus.mem_en && bus.mem_we) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i][15:0]) mism++;
    check(tag, mism, 0);
  endtask

  task automatic set_mem(input int a, input int v);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a[3:0]; bd_data = v[15:0];
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = v;
  endtask

  // Ledger semantics: outcome, reported balance, response latency and writes.
  task automatic model(input int op, input int src, input int dst, input int amt,
                       output bit err, output int bal, output int lat, output int nwr);
    int s, d;
    err = 0; bal = 0; lat = 3; nwr = 0;
    if (src >= 10) begin
      err = 1; bal = 0; lat = 2;
    end else begin
      s = ref_mem[src];
      bal = s;
      case (op)
        0: lat = 3;
        1: if (amt > s) err = 1;
           else begin ref_mem[src] = s - amt; bal = s - amt; lat = 4; nwr = 1; end
        2: if (s + amt > 65535) err = 1;
           else begin ref_mem[src] = s + amt; bal = s + amt; lat = 4; nwr = 1; end
        default: begin
          if (dst >= 10 || dst == src || amt > s) err = 1;
          else begin
            d = ref_mem[dst];
            if (d + amt > 65535) begin err = 1; lat = 5; end
            else begin
              ref_mem[src] = s - amt; ref_mem[dst] = d + amt;
              bal = s - amt; lat = 7; nwr = 2;
            end
          end
        end
      endcase
    end
  endtask

  task automatic drive_req(input int r, input int op, input int src, input int dst, input int amt);
    bus.req_op[2*r +: 2]      = op[1:0];
    bus.req_src[4*r +: 4]     = src[3:0];
    bus.req_dst[4*r +: 4]     = dst[3:0];
    bus.req_amount[16*r +: 16] = amt[15:0];
    bus.req_valid[r]          = 1'b1;
  endtask

  task automatic do_txn(input int r, input int op, input int src, input int dst, input int amt);
    bit exp_err;
    int exp_bal, exp_lat, exp_wr, w0, k;
    bit seen;
    model(op, src, dst, amt, exp_err, exp_bal, exp_lat, exp_wr);
    w0 = wr_cnt;
    @(negedge clk);
    drive_req(r, op, src, dst, amt);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_ready[r]) seen = 1;
    end
    check("req_ready_seen", seen, 1);
    if (seen) begin
      check("req_ready_onehot", bus.req_ready, 1 << r);
      check("busy_at_capture", bus.busy, 1);
    end
    bus.req_valid[r] = 1'b0;
    seen = 0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid[r]) seen = 1;
    end
    check("rsp_valid_seen", seen, 1);
    if (seen) begin
      check("rsp_latency", k, exp_lat);
      check("rsp_valid_onehot", bus.rsp_valid, 1 << r);
      check("rsp_error", bus.rsp_error, exp_err);
      check("rsp_balance", bus.rsp_balance, exp_bal);
    end
    @(negedge clk);
    check("write_count", wr_cnt - w0, exp_wr);
    check_mem("mem_contents");
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    int rsp_cnt, w0, op, src, dst, amt;
    bit rereq, seen;

    tests = 0; fails = 0; cyc = 0; wr_cnt = 0;
    rst_n = 1'b0;
    bd_init = 1'b0; bd_we = 1'b0; bd_addr = 4'd0; bd_data = 16'd0;
    bus.req_valid = '0; bus.req_op = '0; bus.req_src = '0;
    bus.req_dst = '0; bus.req_amount = '0; bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 500;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.rsp_balance,
                            bus.busy, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    bd_init = 1'b1;
    @(negedge clk);
    bd_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {bus.req_ready, bus.rsp_valid, bus.busy, bus.mem_en}, 0);
    check_mem("mem_init");

    // Directed scenarios
    do_txn(0, OP_READ, 3, 0, 0);
    do_txn(1, OP_WITHDRAW, 2, 0, 200);
    check("mem2_after_withdraw", mem[2], 300);
    do_txn(2, OP_WITHDRAW, 2, 0, 400);
    set_mem(5, 65000);
    do_txn(3, OP_DEPOSIT, 5, 0, 600);
    do_txn(0, OP_DEPOSIT, 5, 0, 535);
    check("mem5_after_deposit", mem[5], 65535);
    do_txn(1, OP_TRANSFER, 1, 7, 150);
    check("mem1_after_transfer", mem[1], 350);
    check("mem7_after_transfer", mem[7], 650);
    do_txn(2, OP_TRANSFER, 1, 12, 10);
    do_txn(3, OP_TRANSFER, 1, 1, 10);
    do_txn(0, OP_TRANSFER, 1, 7, 600);
    set_mem(8, 65500);
    do_txn(1, OP_TRANSFER, 0, 8, 100);
    do_txn(2, OP_READ, 11, 0, 0);
    do_txn(3, OP_WITHDRAW, 13, 0, 5);

    // Reset while reading the transfer destination
    w0 = wr_cnt;
    @(negedge clk);
    drive_req(0, OP_TRANSFER, 4, 6, 50);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_ready[0]) seen = 1;
    end
    check("rst_txn_ready_seen", seen, 1);
    bus.req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("rd_dst_mem_en", bus.mem_en, 1);
    check("rd_dst_mem_addr", bus.mem_addr, 6);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.rsp_balance,
                               bus.busy, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    rsp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 4'd0) rsp_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 4'd0) rsp_cnt++;
    end
    check("midreset_no_rsp", rsp_cnt, 0);
    check("midreset_no_write", wr_cnt - w0, 0);
    check_mem("midreset_mem");
    do_txn(3, OP_READ, 4, 0, 0);

    // Round robin: all four at once, then requester 1 re-requests behind 3
    exp_order = '{0, 1, 2, 3, 1};
    @(negedge clk);
    for (int r = 0; r < 4; r++) drive_req(r, OP_READ, r, 0, 0);
    rereq = 0; rsp_cnt = 0;
    for (int i = 0; i < 100 && order.size() < 5; i++) begin
      @(negedge clk);
      rsp_cnt += $countones(bus.rsp_valid);
      for (int r = 0; r < 4; r++) begin
        if (bus.req_ready[r]) begin
          order.push_back(r);
          bus.req_valid[r] = 1'b0;
          if (r == 2 && !rereq) begin
            bus.req_valid[1] = 1'b1;
            rereq = 1;
          end
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rsp_cnt += $countones(bus.rsp_valid);
    end
    check("rr_grant_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) check("rr_grant_order", order[i], exp_order[i]);
    check("rr_rsp_count", rsp_cnt, 5);

    // Randomized transactions against the ledger model
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0) set_mem($urandom_range(0, 9), $urandom_range(60000, 65535));
      op  = $urandom_range(0, 3);
      src = $urandom_range(0, 11);
      dst = ($urandom_range(0, 3) == 0) ? src : $urandom_range(0, 11);
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 400);
      do_txn($urandom_range(0, 3), op, src, dst, amt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_balance_db_arbiter
